// File: rtl/aes_key_sch_inv_pkg.sv
// Shared definitions for the AES-256 inverse key schedule: FSM encoding, step mode,
// round/rcon constants and the forward S-box.
package aes_key_sch_inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPAND  = 2'd1,
        ST_EMIT_LO = 2'd2,
        ST_EMIT_HI = 2'd3
    } state_e;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } step_mode_e;

    localparam logic [7:0] RCON_INIT    = 8'h01;
    localparam logic [7:0] RCON_FINAL   = 8'h40;
    localparam logic [2:0] EXPAND_STEPS = 3'd7;
    localparam logic [3:0] ROUND_LAST   = 4'd14;

    // Byte 0x00 occupies the top byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sch_inv_fun.sv
// One AES-256 key-schedule step over an 8-word block, forward or inverse.
// Both directions share the same two SubWord units (8 S-boxes total).
module aes_key_sch_inv_fun
    import aes_key_sch_inv_pkg::*;
(
    input  step_mode_e   mode_i,
    input  logic [255:0] blk_i,
    input  logic [7:0]   rcon_i,
    output logic [255:0] blk_o
);

    logic [31:0] in_w [8];
    logic [31:0] rcon_word;
    logic [31:0] sub_a_in, sub_a_out, sub_b_in, sub_b_out;
    logic [31:0] f0, f1, f2, f3, f4, f5, f6, f7;
    logic [31:0] i0, i1, i2, i3, i4, i5, i6, i7;

    for (genvar gi = 0; gi < 8; gi++) begin : g_words
        assign in_w[gi] = blk_i[255 - 32*gi -: 32];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign sub_a_out[8*gi +: 8] = sbox(sub_a_in[8*gi +: 8]);
        assign sub_b_out[8*gi +: 8] = sbox(sub_b_in[8*gi +: 8]);
    end

    assign rcon_word = {rcon_i, 24'h000000};

    // Unit A handles RotWord/SubWord of the last word; unit B the mid-block SubWord.
    // The inverse recovers old w7 first so that unit A can rebuild old w0 from it.
    assign i7       = in_w[7] ^ in_w[6];
    assign sub_a_in = (mode_i == MODE_FWD) ? rot_word(in_w[7]) : rot_word(i7);

    assign f0 = in_w[0] ^ sub_a_out ^ rcon_word;
    assign f1 = in_w[1] ^ f0;
    assign f2 = in_w[2] ^ f1;
    assign f3 = in_w[3] ^ f2;

    assign sub_b_in = (mode_i == MODE_FWD) ? f3 : in_w[3];

    assign f4 = in_w[4] ^ sub_b_out;
    assign f5 = in_w[5] ^ f4;
    assign f6 = in_w[6] ^ f5;
    assign f7 = in_w[7] ^ f6;

    assign i6 = in_w[6] ^ in_w[5];
    assign i5 = in_w[5] ^ in_w[4];
    assign i4 = in_w[4] ^ sub_b_out;
    assign i3 = in_w[3] ^ in_w[2];
    assign i2 = in_w[2] ^ in_w[1];
    assign i1 = in_w[1] ^ in_w[0];
    assign i0 = in_w[0] ^ sub_a_out ^ rcon_word;

    assign blk_o = (mode_i == MODE_FWD) ? {f0, f1, f2, f3, f4, f5, f6, f7}
                                        : {i0, i1, i2, i3, i4, i5, i6, i7};

endmodule

// File: rtl/aes_key_sch_inv.sv
// AES-256 key schedule emitting round keys 14..0 for decryption with a valid/next handshake.
// Define AES_KEY_SCH_INV_ZEROIZE_EN to clear the key block when the last round key is taken.
module aes_key_sch_inv
    import aes_key_sch_inv_pkg::*;
(
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inWr,
    input  logic [255:0] inKey,
    input  logic         inNext,
    output logic [127:0] outRoundKey,
    output logic [3:0]   outRoundIdx,
    output logic         outValid,
    output logic         outBusy
);

    state_e       state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   idx_q, idx_d;
    logic [2:0]   step_q, step_d;

    step_mode_e   step_mode;
    logic [255:0] step_blk;
    logic         accept;

    assign step_mode = (state_q == ST_EXPAND) ? MODE_FWD : MODE_INV;

    aes_key_sch_inv_fun u_fun (
        .mode_i (step_mode),
        .blk_i  (key_q),
        .rcon_i (rcon_q),
        .blk_o  (step_blk)
    );

    assign outValid = (state_q == ST_EMIT_LO) || (state_q == ST_EMIT_HI);
    assign outBusy  = (state_q != ST_IDLE);
    assign accept   = outValid && inNext;

    assign outRoundIdx = outValid ? idx_q : 4'd0;
    assign outRoundKey = (state_q == ST_EMIT_HI) ? key_q[127:0] : key_q[255:128];

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            rcon_q  <= RCON_INIT;
            idx_q   <= 4'd0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (inWr) begin
                    key_d   = inKey;
                    step_d  = 3'd1;
                    rcon_d  = RCON_INIT;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                key_d = step_blk;
                // The last forward step keeps rcon so the first inverse step reuses it.
                if (step_q == EXPAND_STEPS) begin
                    rcon_d  = RCON_FINAL;
                    idx_d   = ROUND_LAST;
                    state_d = ST_EMIT_LO;
                end else begin
                    rcon_d = rcon_q << 1;
                    step_d = step_q + 3'd1;
                end
            end
            ST_EMIT_LO: begin
                if (accept) begin
                    if (idx_q != 4'd0) begin
                        key_d   = step_blk;
                        rcon_d  = rcon_q >> 1;
                        idx_d   = idx_q - 4'd1;
                        state_d = ST_EMIT_HI;
                    end else begin
                        state_d = ST_IDLE;
`ifdef AES_KEY_SCH_INV_ZEROIZE_EN
                        key_d   = '0;
`endif
                    end
                end
            end
            ST_EMIT_HI: begin
                if (accept) begin
                    idx_d   = idx_q - 4'd1;
                    state_d = ST_EMIT_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_key_sch_inv.sv
// Directed bench for aes_key_sch_inv: FIPS-197 vectors, handshake stalls, inWr noise and mid-run resets.
module tb_aes_key_sch_inv;

    logic         inClk;
    logic         inRstN;
    logic         inWr;
    logic [255:0] inKey;
    logic         inNext;
    logic [127:0] outRoundKey;
    logic [3:0]   outRoundIdx;
    logic         outValid;
    logic         outBusy;

    int tests_run;
    int tests_failed;

    logic [127:0] got_keys [15];

    localparam logic [255:0] KEY_V1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_V2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_key_sch_inv dut (
        .inClk       (inClk),
        .inRstN      (inRstN),
        .inWr        (inWr),
        .inKey       (inKey),
        .inNext      (inNext),
        .outRoundKey (outRoundKey),
        .outRoundIdx (outRoundIdx),
        .outValid    (outValid),
        .outBusy     (outBusy)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = TB_SBOX[2047 - 8*int'(w[8*k +: 8]) -: 8];
        return r;
    endfunction

    task automatic pulse_reset(input string tag);
        #2;
        inRstN = 1'b0;
        inWr   = 1'b0;
        inNext = 1'b0;
        #1;
        check_eq({tag, "_valid"}, 128'(outValid), 128'd0);
        check_eq({tag, "_busy"},  128'(outBusy),  128'd0);
        check_eq({tag, "_idx"},   128'(outRoundIdx), 128'd0);
        check_eq({tag, "_key"},   outRoundKey, 128'd0);
        @(negedge inClk);
        inRstN = 1'b1;
    endtask

    // abort_mode: 0 full run, 1 reset after 4 expand steps, 2 reset while idx 7 is shown.
    task automatic run_seq(input logic [255:0] key, input int next_pct, input bit noise,
                           input int abort_mode);
        logic [31:0]  w [60];
        logic [31:0]  tmp;
        logic [127:0] rk [15];
        logic [127:0] idle_exp;
        int lat;
        int exp_idx;
        int budget;
        bit acc;

        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0)
                tmp = tb_sub_word({tmp[23:0], tmp[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
            else if (i % 8 == 4)
                tmp = tb_sub_word(tmp);
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        @(negedge inClk);
        inKey  = key;
        inWr   = 1'b1;
        inNext = (next_pct >= 100);
        @(negedge inClk);
        inWr = 1'b0;
        lat  = 0;
        while (!outValid && lat < 20) begin
            if (abort_mode == 1 && lat == 4) begin
                pulse_reset("rst_expand");
                return;
            end
            if (noise) inWr = (lat % 2 == 1);
            @(negedge inClk);
            lat++;
        end
        inWr = 1'b0;
        check_eq("latency", 128'(lat), 128'd7);

        exp_idx = 14;
        budget  = 0;
        while (exp_idx >= 0 && budget < 400) begin
            if (abort_mode == 2 && exp_idx == 7) begin
                pulse_reset("rst_emit");
                return;
            end
            check_eq("valid", 128'(outValid), 128'd1);
            check_eq("idx", 128'(outRoundIdx), 128'(exp_idx));
            check_eq($sformatf("key%0d", exp_idx), outRoundKey, rk[exp_idx]);
            got_keys[exp_idx] = outRoundKey;
            acc    = ($urandom_range(99) < next_pct);
            inNext = acc;
            if (noise) inWr = (exp_idx == 0) ? acc : ($urandom_range(1) == 1);
            @(negedge inClk);
            budget++;
            if (acc) exp_idx--;
        end
        inWr   = 1'b0;
        inNext = (next_pct >= 100);
        check_eq("emit_done", 128'(exp_idx < 0), 128'd1);
        check_eq("end_valid", 128'(outValid), 128'd0);
        check_eq("end_busy", 128'(outBusy), 128'd0);
        check_eq("end_idx", 128'(outRoundIdx), 128'd0);
        @(negedge inClk);
        check_eq("final_wr_ignored", 128'(outBusy), 128'd0);
`ifdef AES_KEY_SCH_INV_ZEROIZE_EN
        idle_exp = 128'd0;
`else
        idle_exp = key[255:128];
`endif
        check_eq("idle_key", outRoundKey, idle_exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        inRstN = 1'b0;
        inWr   = 1'b0;
        inNext = 1'b0;
        inKey  = '0;
        #1;
        check_eq("rst_valid", 128'(outValid), 128'd0);
        check_eq("rst_busy",  128'(outBusy),  128'd0);
        check_eq("rst_idx",   128'(outRoundIdx), 128'd0);
        check_eq("rst_key",   outRoundKey, 128'd0);
        @(negedge inClk);
        @(negedge inClk);
        inRstN = 1'b1;

        run_seq(KEY_V1, 100, 1'b0, 0);
        check_eq("v1_idx14", got_keys[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check_eq("v1_idx1",  got_keys[1],  128'h101112131415161718191a1b1c1d1e1f);
        check_eq("v1_idx0",  got_keys[0],  128'h000102030405060708090a0b0c0d0e0f);

        run_seq(KEY_V2, 30, 1'b1, 0);
        check_eq("v2_idx14", got_keys[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_seq(KEY_V1, 100, 1'b0, 1);
        run_seq(KEY_V2, 60, 1'b0, 2);
        run_seq(KEY_V2, 100, 1'b0, 0);
        check_eq("v2_after_rst_idx14", got_keys[14], 128'hfe4890d1e6188d0b046df344706c631e);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_key_sch_inv.md
AES_KEY_SCH_INV -- requirements
Module: aes_key_sch_inv

Interface
REQ-001 The block SHALL have no parameters; AES-256 widths are fixed.
REQ-002 inClk  input  1  sole clock, all state on rising edge.
REQ-003 inRstN  input  1  asynchronous, active-low reset.
REQ-004 inWr  input  1  load-key strobe, sampled only in IDLE.
REQ-005 inKey  input  256  cipher key, byte 0 in [255:248], word w0 = [255:224].
REQ-006 inNext  input  1  consumer accepts the presented round key.
REQ-007 outRoundKey  output  128  round key in decryption order, w[4r] in [127:96].
REQ-008 outRoundIdx  output  4  index r of the presented key, 14 down to 0.
REQ-009 outValid  output  1  outRoundKey/outRoundIdx valid.
REQ-010 outBusy  output  1  high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, EXPAND, EMIT_LO and EMIT_HI.
REQ-012 IDLE with inWr=1: 256-bit reg <= inKey, step counter <= 1, rcon <= 0x01, next state EXPAND; inWr outside IDLE SHALL be ignored.
REQ-013 EXPAND: each edge applies one forward AES-256 step (RotWord/SubWord/rcon on w7, SubWord on n3), rcon <<= 1; after the 7th step reg holds w56..w63, rcon = 0x40, idx <= 14, next state EMIT_LO.
REQ-014 Latency: outValid SHALL first be high after the 7th rising edge following the edge that sampled inWr.
REQ-015 EMIT_LO presents reg words 0..3; EMIT_HI presents reg words 4..7; outValid=1 in both.
REQ-016 Handshake: a key is accepted on an edge with outValid=1 and inNext=1; inNext while outValid=0 SHALL be ignored; an unaccepted key SHALL hold stable.
REQ-017 Accept in EMIT_LO with idx>0: reg <= inverse step(reg, rcon), rcon >>= 1, idx -= 1, next state EMIT_HI (no bubble).
REQ-018 Inverse step: w7=n7^n6, w6=n6^n5, w5=n5^n4, w4=n4^SubWord(n3), w3=n3^n2, w2=n2^n1, w1=n1^n0, w0=n0^SubWord(RotWord(w7))^rcon.
REQ-019 Accept in EMIT_HI: idx -= 1, next state EMIT_LO.
REQ-020 Accept in EMIT_LO with idx=0: next state IDLE, outValid=0 on the following cycle; an inWr on that same edge is ignored.
REQ-021 Exactly 15 keys SHALL be emitted per load, idx 14..0, no duplicates or gaps.
REQ-022 outRoundIdx SHALL read 0 whenever outValid=0.

Reset
REQ-023 inRstN low SHALL immediately force IDLE, reg=0, rcon=0x01, idx=0, outValid=0, outBusy=0, outRoundKey=0, including mid-EXPAND or mid-EMIT.
REQ-024 After reset release, the first inWr in IDLE SHALL start a fresh sequence.

Configuration
REQ-025 Macro AES_KEY_SCH_INV_ZEROIZE_EN defined: on the edge accepting idx 0, reg SHALL clear to 0, so outRoundKey=0 throughout IDLE.
REQ-026 Macro undefined: reg SHALL retain block w0..w7 in IDLE; outRoundKey shows its low half; outValid still 0.

Structure
REQ-027 Shared package SHALL hold the state encoding, S-box function/table, rcon initial (0x01) and final (0x40) constants, and the step count 7.
REQ-028 One combinational sub-module aes_key_sch_inv_fun SHALL implement forward/inverse step selected by a mode input (8 S-box instances); FSM and registers stay in the top.

Verification
REQ-029 inKey=000102..1f, inNext tied 1 -> first key idx 14 = 24fc79ccbf0979e9371ac23c6d68de36, idx 1 = 101112..1f, idx 0 = 000102..0f, outValid falls after 15 accepts.
REQ-030 inKey=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx 14 = fe4890d1e6188d0b046df344706c631e; all 15 keys match FIPS-197 expansion reversed.
REQ-031 inNext toggled pseudo-randomly (~30%) -> key/idx stable while not accepted, identical 15-key sequence.
REQ-032 inWr pulsed during EXPAND and EMIT -> ignored, sequence unchanged; inWr on final-accept edge -> ignored, block returns to IDLE.
REQ-033 inRstN asserted at EXPAND step 4 and at idx 7 -> all outputs 0 immediately; subsequent load yields correct full sequence.
REQ-034 With and without AES_KEY_SCH_INV_ZEROIZE_EN -> outRoundKey in IDLE after the run is 0 vs 000102..0f respectively.
